// File: rtl/tone_sequencer.sv
// tone_sequencer: programmable stereo step sequencer driving toneL/toneR.
// Per-step L/R note table, beat/step counters, step mask, loop/one-shot.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   beat_tick           one-cycle pulse per beat
//   start, stop         playback control pulses (stop wins)
//   pause               level, freezes position while high
//   loop_en             wrap after the last step (1) or finish (0)
//   step_mask           bit i enables step i, masked steps play SIL
//   wr_en/wr_addr       note-table write port (both halves)
//   wr_toneL/wr_toneR   tone words to write
//   toneL/toneR         registered tone outputs
//   step_idx/beat_idx   current position
//   busy, done          not idle / one-shot completion pulse
module tone_sequencer #(
   parameter int STEPS          = 16,
   parameter int BEATS_PER_STEP = 4,
   parameter int TONE_W         = 32,
   parameter logic [TONE_W-1:0] SIL = TONE_W'(50000000),
   localparam int IDX_W  =
      (STEPS > 2) ? $clog2(STEPS) : 1,
   localparam int BEAT_W =
      (BEATS_PER_STEP > 2) ? $clog2(BEATS_PER_STEP) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              beat_tick,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic              loop_en,
   input  logic [STEPS-1:0]  step_mask,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_addr,
   input  logic [TONE_W-1:0] wr_toneL,
   input  logic [TONE_W-1:0] wr_toneR,
   output logic [TONE_W-1:0] toneL,
   output logic [TONE_W-1:0] toneR,
   output logic [IDX_W-1:0]  step_idx,
   output logic [BEAT_W-1:0] beat_idx,
   output logic              busy,
   output logic              done
);

   localparam logic [IDX_W-1:0]  LAST_STEP =
      IDX_W'(STEPS - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT =
      BEAT_W'(BEATS_PER_STEP - 1);

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      PAUSED
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  step_d;
   logic [BEAT_W-1:0] beat_d;
   logic              done_d;
   logic              play_on;

   logic [TONE_W-1:0] tab_l [STEPS];
   logic [TONE_W-1:0] tab_r [STEPS];

   always_comb begin
      state_d = state_q;
      step_d  = step_idx;
      beat_d  = beat_idx;
      done_d  = 1'b0;
      priority case (1'b1)
         stop: begin
            state_d = IDLE;
            step_d  = '0;
            beat_d  = '0;
         end
         start: begin
            state_d = PLAY;
            step_d  = '0;
            beat_d  = '0;
         end
         (state_q == PAUSED): begin
            if (!pause) state_d = PLAY;
         end
         (state_q == PLAY && pause): begin
            state_d = PAUSED;
         end
         (state_q == PLAY && beat_tick): begin
            if (beat_idx != LAST_BEAT) begin
               beat_d = beat_idx + 1'b1;
            end else begin
               beat_d = '0;
               if (step_idx != LAST_STEP) begin
                  step_d = step_idx + 1'b1;
               end else if (!loop_en) begin
                  // one-shot end: counters back to 0
                  state_d = IDLE;
                  step_d  = '0;
                  done_d  = 1'b1;
               end else begin
                  step_d = '0;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         step_idx <= '0;
         beat_idx <= '0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         step_idx <= step_d;
         beat_idx <= beat_d;
         done     <= done_d;
      end
   end

   assign busy = (state_q != IDLE);

   // Full decode: addresses >= STEPS match no entry.
   always_ff @(posedge clk) begin
      for (int i = 0; i < STEPS; i++) begin
         if (rst) begin
            tab_l[i] <= SIL;
            tab_r[i] <= SIL;
         end else if (wr_en && wr_addr == IDX_W'(i)) begin
            tab_l[i] <= wr_toneL;
            tab_r[i] <= wr_toneR;
         end
      end
   end

   // Tones follow the registered state, so they lag one cycle
   // behind the counters; the mask is applied live.
   assign play_on = (state_q == PLAY) && step_mask[step_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         toneL <= SIL;
         toneR <= SIL;
      end else if (play_on) begin
         toneL <= tab_l[step_idx];
         toneR <= tab_r[step_idx];
      end else begin
         toneL <= SIL;
         toneR <= SIL;
      end
   end

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed bench for tone_sequencer.
// Main build STEPS=16/4 beats, plus a STEPS=12/1 beat build.
module tb_tone_sequencer;

   localparam logic [31:0] SIL = 32'd50000000;

   logic        clk = 1'b0;
   logic        rst, beat_tick, start, stop, pause, loop_en;
   logic [15:0] step_mask;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_toneL, wr_toneR;
   logic [31:0] toneL, toneR;
   logic [3:0]  step_idx;
   logic [1:0]  beat_idx;
   logic        busy, done;

   logic        start2, wr_en2;
   logic [3:0]  wr_addr2;
   logic [11:0] mask2;
   logic [31:0] t12l, t12r;
   logic [3:0]  s12;
   logic [0:0]  b12;
   logic        busy12, done12;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tone_sequencer dut (
      .clk(clk), .rst(rst), .beat_tick(beat_tick),
      .start(start), .stop(stop), .pause(pause),
      .loop_en(loop_en), .step_mask(step_mask),
      .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_toneL(wr_toneL), .wr_toneR(wr_toneR),
      .toneL(toneL), .toneR(toneR),
      .step_idx(step_idx), .beat_idx(beat_idx),
      .busy(busy), .done(done)
   );

   tone_sequencer #(.STEPS(12), .BEATS_PER_STEP(1)) u12 (
      .clk(clk), .rst(rst), .beat_tick(beat_tick),
      .start(start2), .stop(stop), .pause(pause),
      .loop_en(loop_en), .step_mask(mask2),
      .wr_en(wr_en2), .wr_addr(wr_addr2),
      .wr_toneL(wr_toneL), .wr_toneR(wr_toneR),
      .toneL(t12l), .toneR(t12r),
      .step_idx(s12), .beat_idx(b12),
      .busy(busy12), .done(done12)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d",
                tag, obs, exp);
      end
   endtask

   task automatic pos(input string tag, input int s,
                      input int b, input int bz, input int dn);
      chk({tag, " step"}, 32'(step_idx), s);
      chk({tag, " beat"}, 32'(beat_idx), b);
      chk({tag, " busy"}, 32'(busy), bz);
      chk({tag, " done"}, 32'(done), dn);
   endtask

   task automatic tones(input string tag,
                        input int l, input int r);
      chk({tag, " toneL"}, toneL, l);
      chk({tag, " toneR"}, toneR, r);
   endtask

   task automatic tick();
      beat_tick = 1'b1;
      cyc();
      beat_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         tick();
         cyc();
         cyc();
      end
   endtask

   task automatic go();
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
   endtask

   task automatic halt();
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      cyc();
   endtask

   initial begin
      rst = 1'b1; beat_tick = 0; start = 0; stop = 0;
      pause = 0; loop_en = 0; step_mask = '1;
      wr_en = 0; wr_addr = '0; wr_toneL = '0; wr_toneR = '0;
      start2 = 0; wr_en2 = 0; wr_addr2 = '0; mask2 = '1;
      cyc();
      cyc();
      rst = 1'b0;
      pos("reset", 0, 0, 0, 0);
      tones("reset", SIL, SIL);

      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1;
         wr_addr = 4'(i);
         wr_toneL = 262 + i;
         wr_toneR = 262 + i;
         cyc();
      end
      wr_en = 1'b0;

      // one-shot over all 64 beats
      loop_en = 1'b0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("start busy", 32'(busy), 1);
      tones("start lag", SIL, SIL);
      cyc();
      tones("step0", 262, 262);
      for (int k = 1; k <= 64; k++) begin
         tick();
         if (k < 64) pos("os", k / 4, k % 4, 1, 0);
         else pos("os end", 0, 0, 0, 1);
         cyc();
         if (k < 64) tones("os", 262 + k / 4, 262 + k / 4);
         else tones("os end", SIL, SIL);
         chk("os done", 32'(done), 0);
         repeat (8) cyc();
      end
      chk("os idle busy", 32'(busy), 0);

      // looping playback
      loop_en = 1'b1;
      go();
      for (int k = 1; k <= 70; k++) begin
         tick();
         pos("loop", (k / 4) % 16, k % 4, 1, 0);
         cyc();
         tones("loop", 262 + (k / 4) % 16, 262 + (k / 4) % 16);
         repeat (8) cyc();
      end
      halt();
      pos("stop", 0, 0, 0, 0);
      tones("stop", SIL, SIL);

      // step mask
      step_mask = 16'hAAAA;
      go();
      tones("mask s0", SIL, SIL);
      ticks(4);
      tones("mask s1", 263, 263);
      ticks(4);
      tones("mask s2", SIL, SIL);
      ticks(4);
      tones("mask s3", 265, 265);
      step_mask = 16'hAAA2;
      cyc();
      tones("mask off3", SIL, SIL);
      step_mask = 16'hAAAA;
      cyc();
      tones("mask on3", 265, 265);
      halt();

      // pause at step 5 beat 2
      step_mask = '1;
      go();
      ticks(22);
      pos("pre pause", 5, 2, 1, 0);
      tones("pre pause", 267, 267);
      pause = 1'b1;
      cyc();
      pos("paused", 5, 2, 1, 0);
      cyc();
      tones("paused", SIL, SIL);
      ticks(3);
      pos("paused tk", 5, 2, 1, 0);
      tones("paused tk", SIL, SIL);
      pause = 1'b0;
      cyc();
      cyc();
      pos("resume", 5, 2, 1, 0);
      tones("resume", 267, 267);
      tick();
      pos("resume t1", 5, 3, 1, 0);
      cyc();
      tick();
      pos("resume t2", 6, 0, 1, 0);
      cyc();
      cyc();
      tones("resume s6", 268, 268);

      // start+tick, then stop+start
      start = 1'b1;
      beat_tick = 1'b1;
      cyc();
      start = 1'b0;
      beat_tick = 1'b0;
      pos("start+tick", 0, 0, 1, 0);
      tick();
      pos("after st+tk", 0, 1, 1, 0);
      cyc();
      stop = 1'b1;
      start = 1'b1;
      cyc();
      stop = 1'b0;
      start = 1'b0;
      pos("stop+start", 0, 0, 0, 0);
      cyc();
      tones("stop+start", SIL, SIL);

      // live write to the current step, then reset
      go();
      ticks(8);
      pos("pre wr", 2, 0, 1, 0);
      tones("pre wr", 264, 264);
      wr_en = 1'b1;
      wr_addr = 4'd2;
      wr_toneL = 880;
      wr_toneR = 440;
      cyc();
      wr_en = 1'b0;
      tones("wr lag", 264, 264);
      cyc();
      tones("wr", 880, 440);
      pos("wr play", 2, 0, 1, 0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      pos("mid rst", 0, 0, 0, 0);
      tones("mid rst", SIL, SIL);
      go();
      tones("clr s0", SIL, SIL);
      ticks(8);
      pos("clr s2 pos", 2, 0, 1, 0);
      tones("clr s2", SIL, SIL);
      halt();

      // STEPS=12 build: out-of-range writes ignored
      for (int i = 0; i < 16; i++) begin
         wr_en2 = 1'b1;
         wr_addr2 = 4'(i);
         wr_toneL = (i < 12) ? 100 + i : 999;
         wr_toneR = (i < 12) ? 200 + i : 999;
         cyc();
      end
      wr_en2 = 1'b0;
      loop_en = 1'b0;
      start2 = 1'b1;
      cyc();
      start2 = 1'b0;
      cyc();
      chk("s12 L0", t12l, 100);
      chk("s12 R0", t12r, 200);
      for (int i = 1; i < 12; i++) begin
         tick();
         chk("s12 step", 32'(s12), i);
         cyc();
         chk("s12 L", t12l, 100 + i);
         chk("s12 R", t12r, 200 + i);
      end
      tick();
      chk("s12 done", 32'(done12), 1);
      chk("s12 busy", 32'(busy12), 0);
      chk("s12 step end", 32'(s12), 0);
      cyc();
      chk("s12 done off", 32'(done12), 0);
      chk("s12 L end", t12l, SIL);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
